// File: rtl/uart_echo_fifo.sv
// UART loopback bridge: 2-flop synchronised receiver feeding a circular FIFO that drains into a
// transmitter with the same frame format (configurable data bits, parity and stop bits).
module uart_echo_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RxD,
    output logic                          TxD,
    input  logic                          loopback_en,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BitEnd  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfEnd = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LastBit = BW'(DATA_BITS - 1);
    localparam logic          LastStop = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWait} rx_state_e;
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

    function automatic logic calc_par(input logic [DATA_BITS-1:0] w);
        return (PARITY == 1) ? ~^w : ^w;
    endfunction

    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= RxD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    rx_state_e            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_valid_q, rx_valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 par_bad;

    assign par_bad = (PARITY != 0) && (rx_par_q != calc_par(rx_shift_q));

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) rx_state_d = RxStart;
            end
            RxStart: if (rx_cnt_q == HalfEnd) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rxd_sync_q ? RxIdle : RxData;
            end
            RxData: if (rx_cnt_q == BitEnd) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                rx_bit_d   = rx_bit_q + BW'(1);
                if (rx_bit_q == LastBit) rx_state_d = (PARITY != 0) ? RxParity : RxStop;
            end
            RxParity: if (rx_cnt_q == BitEnd) begin
                rx_cnt_d   = '0;
                rx_par_d   = rxd_sync_q;
                rx_state_d = RxStop;
            end
            RxStop: if (rx_cnt_q == BitEnd) begin
                rx_cnt_d = '0;
                // A low stop bit outranks a parity mismatch and must see the line go idle first.
                if (!rxd_sync_q) begin
                    ferr_d     = 1'b1;
                    rx_state_d = RxWait;
                end else if (par_bad) begin
                    perr_d     = 1'b1;
                    rx_state_d = RxIdle;
                end else begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_state_d = RxIdle;
                end
            end
            RxWait: begin
                rx_cnt_d = '0;
                if (rxd_sync_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // FIFO is written the cycle after rx_valid, from the registered rx_data.
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [AW:0]          count_q, count_d;
    logic                 ovf_q, full, wr_en, tx_pop;

    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign wr_en = rx_valid_q && (!full || tx_pop);

    always_comb begin
        count_d = count_q;
        if (wr_en && !tx_pop) count_d = count_q + (AW+1)'(1);
        else if (!wr_en && tx_pop) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en) mem_q[wptr_q] <= rx_data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + AW'(1);
            if (tx_pop) rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
            if (rx_valid_q && full && !tx_pop) ovf_q <= 1'b1;
        end
    end

    tx_state_e            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_stop_q, tx_stop_d, txd_q, txd_d;
    logic                 can_pop;

    assign can_pop = loopback_en && (count_q != '0);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_stop_d  = tx_stop_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (can_pop) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = mem_q[rptr_q];
                    tx_par_d   = calc_par(mem_q[rptr_q]);
                    tx_state_d = TxStart;
                    txd_d      = 1'b0;
                end
            end
            TxStart: if (tx_cnt_q == BitEnd) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = TxData;
                txd_d      = tx_shift_q[0];
            end
            TxData: if (tx_cnt_q == BitEnd) begin
                tx_cnt_d = '0;
                if (tx_bit_q == LastBit) begin
                    tx_stop_d  = 1'b0;
                    tx_state_d = (PARITY != 0) ? TxParity : TxStop;
                    txd_d      = (PARITY != 0) ? tx_par_q : 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + BW'(1);
                    tx_shift_d = tx_shift_q >> 1;
                    txd_d      = tx_shift_q[1];
                end
            end
            TxParity: if (tx_cnt_q == BitEnd) begin
                tx_cnt_d   = '0;
                tx_state_d = TxStop;
                txd_d      = 1'b1;
            end
            TxStop: if (tx_cnt_q == BitEnd) begin
                tx_cnt_d = '0;
                if (tx_stop_q != LastStop) begin
                    tx_stop_d = 1'b1;
                end else if (can_pop) begin
                    // Chain straight into the next start bit with no idle gap.
                    tx_pop     = 1'b1;
                    tx_shift_d = mem_q[rptr_q];
                    tx_par_d   = calc_par(mem_q[rptr_q]);
                    tx_state_d = TxStart;
                    txd_d      = 1'b0;
                end else begin
                    tx_state_d = TxIdle;
                    txd_d      = 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_stop_q  <= tx_stop_d;
            txd_q      <= txd_d;
        end
    end

    assign TxD        = txd_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule
